ram_arbiter: RTL and testbench

Parametrised N-client arbiter that shares one single-ported RAM among several clients, all using the same request/response RAM protocol (en, addr, data_w, we, be, data_r, delay). It sits between core-side clients (instruction fetch, load/store, DMA, debug) and one memory. It adds round-robin or fixed-priority arbitration, per-client stall signalling and grant locking while the memory itself stalls. A single client reduces the block to a pass-through with the same delay semantics.

---
 rtl/ram_arbiter.sv | 93 +++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM among N_CLIENTS request/response clients.
// Arbitration is round-robin or fixed priority, and the grant is held while the memory stalls.
module ram_arbiter #(
  parameter  int N_CLIENTS  = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int ARB_MODE   = 1,
  localparam int BYTE_COUNT = DATA_WIDTH / 8,
  localparam int PTR_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             cl_en,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_data_w,
  input  logic [N_CLIENTS-1:0]             cl_we,
  input  logic [N_CLIENTS*BYTE_COUNT-1:0]  cl_be,
  output logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_data_r,
  output logic [N_CLIENTS-1:0]             cl_delay,
  output logic                             m_en,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_data_w,
  output logic                             m_we,
  output logic [BYTE_COUNT-1:0]            m_be,
  input  logic [DATA_WIDTH-1:0]            m_data_r,
  input  logic                             m_delay
);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     resp_owner;
  logic [PTR_W-1:0]     win;
  logic                 resp_valid;
  logic                 lock;
  logic [N_CLIENTS-1:0] req_q;

  // Loops run from the lowest-priority candidate upward so the last hit is the winner.
  always_comb begin
    lock = resp_valid & m_delay;
    win  = '0;
    if (lock) begin
      win = resp_owner;
    end else if (ARB_MODE == 0) begin
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
        if (cl_en[i]) win = PTR_W'(i);
      end
    end else begin
      for (int k = N_CLIENTS; k >= 1; k--) begin
        if (cl_en[(int'(rr_ptr) + k) % N_CLIENTS])
          win = PTR_W'((int'(rr_ptr) + k) % N_CLIENTS);
      end
    end
  end

  always_comb begin
    m_en     = |cl_en;
    m_addr   = cl_addr[ADDR_WIDTH-1:0];
    m_data_w = cl_data_w[DATA_WIDTH-1:0];
    m_we     = cl_we[0];
    m_be     = cl_be[BYTE_COUNT-1:0];
    for (int i = 1; i < N_CLIENTS; i++) begin
      if (win == PTR_W'(i)) begin
        m_addr   = cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_data_w = cl_data_w[i*DATA_WIDTH +: DATA_WIDTH];
        m_we     = cl_we[i];
        m_be     = cl_be[i*BYTE_COUNT +: BYTE_COUNT];
      end
    end
  end

  assign cl_data_r = {N_CLIENTS{m_data_r}};

  always_comb begin
    cl_delay = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cl_delay[i] = req_q[i] & (~resp_valid | (resp_owner != PTR_W'(i)) | m_delay);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= PTR_W'(N_CLIENTS - 1);
      resp_valid <= 1'b0;
      resp_owner <= '0;
      req_q      <= '0;
    end else begin
      resp_valid <= m_en;
      resp_owner <= win;
      req_q      <= cl_en;
      if (m_en && !lock) rr_ptr <= win;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a fixed-priority and a round-robin instance share the same client stimulus
// and are compared each cycle against a rule-level model, plus directed scenarios.
module tb_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BC = DW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    cl_en;
  logic [N-1:0]    cl_we;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_data_w;
  logic [N*BC-1:0] cl_be;
  logic [DW-1:0]   m_data_r;
  logic            m_delay;

  // index 0: fixed priority, index 1: round-robin
  logic [N*DW-1:0] o_data_r [2];
  logic [N-1:0]    o_delay  [2];
  logic            o_en     [2];
  logic [AW-1:0]   o_addr   [2];
  logic [DW-1:0]   o_data_w [2];
  logic            o_we     [2];
  logic [BC-1:0]   o_be     [2];

  int n_chk = 0;
  int n_err = 0;

  int          md_rr    [2];
  bit          md_rv    [2];
  int          md_owner [2];
  logic [N-1:0] md_req  [2];

  always #5 clk = ~clk;

  ram_arbiter #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) u_fixed (
    .clk(clk), .reset(reset), .cl_en(cl_en), .cl_addr(cl_addr), .cl_data_w(cl_data_w),
    .cl_we(cl_we), .cl_be(cl_be), .cl_data_r(o_data_r[0]), .cl_delay(o_delay[0]),
    .m_en(o_en[0]), .m_addr(o_addr[0]), .m_data_w(o_data_w[0]), .m_we(o_we[0]),
    .m_be(o_be[0]), .m_data_r(m_data_r), .m_delay(m_delay));

  ram_arbiter #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .cl_en(cl_en), .cl_addr(cl_addr), .cl_data_w(cl_data_w),
    .cl_we(cl_we), .cl_be(cl_be), .cl_data_r(o_data_r[1]), .cl_delay(o_delay[1]),
    .m_en(o_en[1]), .m_addr(o_addr[1]), .m_data_w(o_data_w[1]), .m_we(o_we[1]),
    .m_be(o_be[1]), .m_data_r(m_data_r), .m_delay(m_delay));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h0000_1000 + 32'(i) * 32'h100;
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < N; i++) begin
      cl_addr[i*AW +: AW]   = addr_of(i);
      cl_data_w[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      cl_be[i*BC +: BC]     = '1;
    end
    cl_we = '0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      md_rr[d] = N - 1; md_rv[d] = 0; md_owner[d] = 0; md_req[d] = '0;
    end
  endtask

  function automatic int exp_winner(input int d);
    if (md_rv[d] && m_delay) return md_owner[d];
    if (cl_en == '0) return 0;
    if (d == 0) begin
      for (int i = 0; i < N; i++) if (cl_en[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (cl_en[(md_rr[d] + k) % N]) return (md_rr[d] + k) % N;
    end
    return 0;
  endfunction

  task automatic check_all();
    int w;
    logic [N-1:0] dly;
    #1;
    for (int d = 0; d < 2; d++) begin
      w = exp_winner(d);
      for (int i = 0; i < N; i++)
        dly[i] = md_req[d][i] && (!md_rv[d] || i != md_owner[d] || m_delay);
      check($sformatf("m_en[%0d]", d),     o_en[d],     |cl_en);
      check($sformatf("m_addr[%0d]", d),   o_addr[d],   cl_addr[w*AW +: AW]);
      check($sformatf("m_data_w[%0d]", d), o_data_w[d], cl_data_w[w*DW +: DW]);
      check($sformatf("m_we[%0d]", d),     o_we[d],     cl_we[w]);
      check($sformatf("m_be[%0d]", d),     o_be[d],     cl_be[w*BC +: BC]);
      check($sformatf("cl_delay[%0d]", d), o_delay[d],  dly);
      check($sformatf("cl_data_r[%0d]", d), o_data_r[d], {N{m_data_r}});
    end
  endtask

  task automatic advance();
    int w [2];
    bit lk [2];
    for (int d = 0; d < 2; d++) begin
      w[d]  = exp_winner(d);
      lk[d] = md_rv[d] && m_delay;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (cl_en != '0 && !lk[d]) md_rr[d] = w[d];
      md_rv[d]    = (cl_en != '0);
      md_owner[d] = w[d];
      md_req[d]   = cl_en;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    #1;
    check("rst_async_dly0", o_delay[0], '0);
    check("rst_async_dly1", o_delay[1], '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; cl_en = '0; m_delay = 1'b0; m_data_r = '0;
    set_defaults();
    model_reset();

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cl_en = N'($urandom); m_delay = 1'($urandom);
      #1;
      check("rst_hold_dly0", o_delay[0], '0);
      check("rst_hold_dly1", o_delay[1], '0);
    end
    @(negedge clk);
    reset = 1'b1; cl_en = '0; m_delay = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_all();
      check("idle_en", o_en[1], 1'b0);
      check("idle_dly", o_delay[1], '0);
      advance();
    end

    // single read from client 1
    cl_en = 4'b0010; cl_addr[1*AW +: AW] = 32'h10; m_data_r = 32'hCAFEF00D;
    check_all();
    check("rd_addr", o_addr[1], 32'h10);
    check("rd_en", o_en[1], 1'b1);
    advance();
    cl_en = '0;
    check_all();
    check("rd_dly", o_delay[1][1], 1'b0);
    check("rd_data", o_data_r[1][1*DW +: DW], 32'hCAFEF00D);
    advance();
    set_defaults();

    // clients 0 and 2 contend continuously
    reset_dut();
    cl_en = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      check_all();
      check("rr_grant", o_addr[1], addr_of((k % 2 == 0) ? 0 : 2));
      if (k > 0) check("rr_dly", o_delay[1], (k % 2 == 1) ? 4'b0100 : 4'b0001);
      check("fp_grant", o_addr[0], addr_of(0));
      advance();
    end

    // memory stall while client 3 owns the response
    reset_dut();
    cl_en = 4'b1000; m_delay = 1'b0;
    check_all();
    check("stall_g0", o_addr[1], addr_of(3));
    advance();
    cl_en = 4'b1001; m_delay = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check_all();
      for (int d = 0; d < 2; d++) begin
        check("stall_lock_addr", o_addr[d], addr_of(3));
        check("stall_dly3", o_delay[d][3], 1'b1);
      end
      advance();
    end
    m_delay = 1'b0; cl_en = 4'b0001;
    check_all();
    for (int d = 0; d < 2; d++) begin
      check("stall_done_dly3", o_delay[d][3], 1'b0);
      check("stall_next_grant", o_addr[d], addr_of(0));
    end
    advance();

    // fixed priority: client 0 starves client 1 until it drops
    reset_dut();
    cl_en = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      check_all();
      check("fp_win0", o_addr[0], addr_of(0));
      if (k > 0) check("fp_dly1", o_delay[0][1], 1'b1);
      advance();
    end
    cl_en = 4'b0010;
    check_all();
    check("fp_win1", o_addr[0], addr_of(1));
    advance();

    // reset while client 2 holds a locked response
    reset_dut();
    cl_en = 4'b0100; m_delay = 1'b0;
    check_all();
    advance();
    cl_en = 4'b0111; m_delay = 1'b1;
    check_all();
    check("lock_dly2", o_delay[1][2], 1'b1);
    reset_dut();
    m_delay = 1'b0; cl_en = 4'b0111;
    check_all();
    check("post_rst_rr", o_addr[1], addr_of(0));
    check("post_rst_fp", o_addr[0], addr_of(0));
    advance();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cl_en = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cl_addr[i*AW +: AW]   = $urandom;
          cl_data_w[i*DW +: DW] = $urandom;
          cl_be[i*BC +: BC]     = BC'($urandom);
          cl_we[i]              = 1'($urandom);
        end
      end
      m_delay  = ($urandom_range(0, 3) == 0);
      m_data_r = $urandom;
      if ($urandom_range(0, 60) == 0) reset_dut();
      check_all();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
